// File: rtl/mux_rr_arbiter_if.sv
// Handshake and data bundle between four requesters, the round-robin arbiter
// and the downstream consumer of the shared mux output.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 2
);
    logic [3:0]       req;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [WIDTH-1:0] I4;
    logic             ready;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] O;
    logic             O_valid;
    logic             busy;

    modport master (
        output req, I1, I2, I3, I4, ready,
        input  sel, gnt, O, O_valid, busy
    );

    modport slave (
        input  req, I1, I2, I3, I4, ready,
        output sel, gnt, O, O_valid, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: grants one requester at a time for
// at most MAX_HOLD transfers and registers each accepted word onto O.
module mux_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] word_s [4];
    logic [1:0]       pick_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Scan last+1..last+4; walking downward lets the nearest requester win.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] res;
        res = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign word_s[0] = bus.I1;
    assign word_s[1] = bus.I2;
    assign word_s[2] = bus.I3;
    assign word_s[3] = bus.I4;
    assign pick_s    = rr_pick(bus.req, last_q);

    // Next-state and output decode for the IDLE/GRANT sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        o_d        = o_q;
        o_valid_d  = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    sel_d      = pick_s;
                    gnt_d      = onehot4(pick_s);
                    busy_d     = 1'b1;
                    hold_cnt_d = 4'd0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel_q]) begin
                    last_d  = sel_q;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.ready) begin
                    o_d        = word_s[sel_q];
                    o_valid_d  = 1'b1;
                    hold_cnt_d = hold_cnt_q + 4'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        last_d  = sel_q;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else begin
                    // Backpressure: hold grant and count, no timeout.
                    state_d = ST_GRANT;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            last_q     <= 2'd3;
            gnt_q      <= 4'b0000;
            hold_cnt_q <= 4'd0;
            o_q        <= '0;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.O       = o_q;
    assign bus.O_valid = o_valid_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus queues expected words, grant
// order and per-cycle snapshots; a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;
    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             busy;
        logic             ov;
        logic [WIDTH-1:0] o;
        bit               chk_sel;
        bit               chk_ov;
        bit               chk_o;
        int               tag;
    } snap_t;

    logic clk;
    logic rst_n;
    bit   done;
    int   vectors;
    int   miscompares;
    int   snap_tag;

    snap_t            snap_q[$];
    logic [WIDTH-1:0] exp_data_q[$];
    logic [3:0]       exp_gnt_q[$];

    mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void expect_snap(input logic [3:0] g, input logic [1:0] s, input logic b,
                                        input logic ov, input logic [WIDTH-1:0] o,
                                        input bit cs, input bit cov, input bit co);
        snap_t e;
        e.gnt = g; e.sel = s; e.busy = b; e.ov = ov; e.o = o;
        e.chk_sel = cs; e.chk_ov = cov; e.chk_o = co; e.tag = snap_tag;
        snap_tag++;
        snap_q.push_back(e);
    endfunction

    function automatic void cmp(input string name, input int tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s (tag %0d): actual %0h, required %0h", name, tag, act, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        expect_snap(4'b0000, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick(1);
        rst_n = 1'b1;
    endtask

    // Monitor: snapshots, grant order, output words and the grant invariant.
    initial begin
        snap_t      e;
        logic [3:0] prev_gnt;
        logic [3:0] g;
        logic [3:0] inv;
        logic [WIDTH-1:0] d;
        prev_gnt = 4'b0000;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                e = snap_q.pop_front();
                cmp("snap_gnt", e.tag, int'(bus.gnt), int'(e.gnt));
                cmp("snap_busy", e.tag, int'(bus.busy), int'(e.busy));
                if (e.chk_sel) cmp("snap_sel", e.tag, int'(bus.sel), int'(e.sel));
                if (e.chk_ov)  cmp("snap_O_valid", e.tag, int'(bus.O_valid), int'(e.ov));
                if (e.chk_o)   cmp("snap_O", e.tag, int'(bus.O), int'(e.o));
            end
            inv = bus.busy ? (4'b0001 << bus.sel) : 4'b0000;
            cmp("gnt_invariant", -1, int'(bus.gnt), int'(inv));
            if (rst_n) begin
                if (bus.O_valid) begin
                    if (exp_data_q.size() == 0) begin
                        cmp("unexpected_O_valid", -1, int'(bus.O_valid), 0);
                    end else begin
                        d = exp_data_q.pop_front();
                        cmp("O_word", -1, int'(bus.O), int'(d));
                    end
                end
                if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                    if (exp_gnt_q.size() == 0) begin
                        cmp("unexpected_grant", -1, int'(bus.gnt), 0);
                    end else begin
                        g = exp_gnt_q.pop_front();
                        cmp("grant_order", -1, int'(bus.gnt), int'(g));
                    end
                end
            end
            prev_gnt = bus.gnt;
            if (done) begin
                cmp("words_outstanding", -1, exp_data_q.size(), 0);
                cmp("grants_outstanding", -1, exp_gnt_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int phase;
        int who;
        logic [3:0] g;
        done = 1'b0; vectors = 0; miscompares = 0; snap_tag = 0;
        rst_n = 1'b0; bus.req = 4'b0000; bus.ready = 1'b0;
        bus.I1 = 2'b00; bus.I2 = 2'b00; bus.I3 = 2'b00; bus.I4 = 2'b00;
        tick(2);
        expect_snap(4'b0000, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick(1);
        rst_n = 1'b1;

        // Single request: one transfer of I1.
        bus.req = 4'b0001; bus.I1 = 2'b10; bus.ready = 1'b1;
        exp_gnt_q.push_back(4'b0001);
        exp_data_q.push_back(2'b10);
        tick(1);
        expect_snap(4'b0001, 2'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_snap(4'b0001, 2'd0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick(3);

        // Full rotation 0,1,2,3,0 with four transfers each and a one-cycle gap.
        apply_reset();
        bus.I1 = 2'd0; bus.I2 = 2'd1; bus.I3 = 2'd2; bus.I4 = 2'd3;
        bus.req = 4'b1111; bus.ready = 1'b1;
        exp_gnt_q.push_back(4'b0001); exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) exp_data_q.push_back(2'(w));
        end
        for (int c = 1; c <= 21; c++) begin
            tick(1);
            phase = (c - 1) % 5;
            who   = ((c - 1) / 5) % 4;
            g     = (phase == 4) ? 4'b0000 : (4'b0001 << who);
            expect_snap(g, 2'(who), phase != 4, phase != 0, 2'(who), 1'b1, 1'b1, phase != 0);
        end
        bus.req = 4'b0000;
        tick(3);

        // Backpressure on requester 1: one transfer, 5 stalled cycles, 3 more.
        apply_reset();
        bus.I2 = 2'b01; bus.req = 4'b0010; bus.ready = 1'b1;
        exp_gnt_q.push_back(4'b0010);
        for (int k = 0; k < 4; k++) exp_data_q.push_back(2'b01);
        tick(1);
        expect_snap(4'b0010, 2'd1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_snap(4'b0010, 2'd1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        bus.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            expect_snap(4'b0010, 2'd1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        end
        bus.ready = 1'b1;
        tick(2);
        expect_snap(4'b0010, 2'd1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        tick(1);
        expect_snap(4'b0000, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick(2);

        // Early drop by requester 2; next grant goes to 3, not 0.
        apply_reset();
        bus.I3 = 2'b11; bus.req = 4'b0100; bus.ready = 1'b1;
        exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b1000);
        exp_data_q.push_back(2'b11); exp_data_q.push_back(2'b11);
        tick(1);
        expect_snap(4'b0100, 2'd2, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        tick(2);
        expect_snap(4'b0100, 2'd2, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
        bus.req = 4'b1001;
        tick(1);
        expect_snap(4'b0000, 2'd2, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_snap(4'b1000, 2'd3, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick(3);

        // Lone requester 2 is re-granted after each hold limit.
        apply_reset();
        bus.I3 = 2'b10; bus.req = 4'b0100; bus.ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_gnt_q.push_back(4'b0100);
        for (int k = 0; k < 8; k++) exp_data_q.push_back(2'b10);
        for (int c = 1; c <= 11; c++) begin
            tick(1);
            phase = (c - 1) % 5;
            g     = (phase == 4) ? 4'b0000 : 4'b0100;
            expect_snap(g, 2'd2, phase != 4, phase != 0, 2'b10, 1'b1, 1'b1, phase != 0);
        end
        bus.req = 4'b0000;
        tick(3);

        // Asynchronous reset between edges right after a transfer.
        apply_reset();
        bus.I1 = 2'b01; bus.req = 4'b1111; bus.ready = 1'b1;
        exp_gnt_q.push_back(4'b0001);
        tick(2);
        #2;
        rst_n = 1'b0;
        expect_snap(4'b0000, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick(1);
        rst_n = 1'b1;
        exp_gnt_q.push_back(4'b0001);
        tick(1);
        expect_snap(4'b0001, 2'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick(3);

        done = 1'b1;
        tick(10);
        $display("FAIL watchdog: monitor did not close the run");
        $fatal(1);
    end
endmodule
